// File: rtl/display_timing_pkg.sv
// Shared types and constants for the display timing generator.
//   CNT_W        : width of every length field, per-axis counter and pixel coordinate.
//   cnt_t        : CNT_W-wide unsigned counter / length type.
//   axis_state_t : per-axis raster phase, ACTIVE -> FP -> SYNC -> BP -> ACTIVE.
//   axis_cfg_t   : the four field lengths of one axis.
//   ctrl_state_t : top-level IDLE/run control state.
//   last_idx()   : terminal count for a field; a zero length behaves as one.
package display_timing_pkg;

    localparam int unsigned CNT_W = 12;

    typedef logic [CNT_W-1:0] cnt_t;

    typedef enum logic [1:0] {
        ST_ACTIVE = 2'd0,
        ST_FP     = 2'd1,
        ST_SYNC   = 2'd2,
        ST_BP     = 2'd3
    } axis_state_t;

    typedef struct packed {
        cnt_t active;
        cnt_t fp;
        cnt_t sync;
        cnt_t bp;
    } axis_cfg_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } ctrl_state_t;

    // Zero-length fields are clamped to one so no phase is ever skipped.
    function automatic cnt_t last_idx(input cnt_t len);
        return (len == '0) ? '0 : cnt_t'(len - cnt_t'(1));
    endfunction

endpackage

// File: rtl/display_timing_gen_if.sv
// Mode-register and video-timing bundle of the display timing generator.
//   master : register file / testbench side (drives cfg_*, observes timing outputs).
//   slave  : display_timing_gen side (consumes cfg_*, drives timing outputs).
// Signals:
//   cfg_enable                  run request
//   cfg_{h,v}_{active,fp,sync,bp} field lengths (cycles for H, lines for V)
//   cfg_hs_pol, cfg_vs_pol      1 = sync active-low
//   hsync, vsync, de            sync outputs with polarity applied, active pixel
//   pix_x, pix_y                current pixel coordinate, valid while de=1
//   frame_start, line_start     one-cycle pulses on (0,0) and x=0 of active lines
//   running                     generator not idle
interface display_timing_gen_if;
    import display_timing_pkg::*;

    logic cfg_enable;
    cnt_t cfg_h_active;
    cnt_t cfg_h_fp;
    cnt_t cfg_h_sync;
    cnt_t cfg_h_bp;
    cnt_t cfg_v_active;
    cnt_t cfg_v_fp;
    cnt_t cfg_v_sync;
    cnt_t cfg_v_bp;
    logic cfg_hs_pol;
    logic cfg_vs_pol;

    logic hsync;
    logic vsync;
    logic de;
    cnt_t pix_x;
    cnt_t pix_y;
    logic frame_start;
    logic line_start;
    logic running;

    modport master (
        output cfg_enable,
        output cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp,
        output cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp,
        output cfg_hs_pol, cfg_vs_pol,
        input  hsync, vsync, de, pix_x, pix_y, frame_start, line_start, running
    );

    modport slave (
        input  cfg_enable,
        input  cfg_h_active, cfg_h_fp, cfg_h_sync, cfg_h_bp,
        input  cfg_v_active, cfg_v_fp, cfg_v_sync, cfg_v_bp,
        input  cfg_hs_pol, cfg_vs_pol,
        output hsync, vsync, de, pix_x, pix_y, frame_start, line_start, running
    );

endinterface

// File: rtl/display_timing_axis.sv
// One raster axis: ACTIVE -> FP -> SYNC -> BP -> ACTIVE with a per-phase counter.
//   ACLK, ARESETN : pixel clock, asynchronous active-low reset
//   clr_i         : force phase ACTIVE, count 0 (held while the generator is idle)
//   adv_i         : advance one step (every cycle for H, once per line for V)
//   cfg_i         : field lengths for this axis
//   state_o       : current phase
//   count_o       : position inside the current phase
//   last_o        : final step of BP, i.e. end of the axis period
module display_timing_axis
    import display_timing_pkg::*;
(
    input  logic        ACLK,
    input  logic        ARESETN,
    input  logic        clr_i,
    input  logic        adv_i,
    input  axis_cfg_t   cfg_i,
    output axis_state_t state_o,
    output cnt_t        count_o,
    output logic        last_o
);

    axis_state_t state_q, state_d;
    axis_state_t state_nxt;
    cnt_t        cnt_q, cnt_d;
    cnt_t        len_m1;
    logic        phase_end;

    always_comb begin
        len_m1    = '0;
        state_nxt = ST_ACTIVE;
        unique case (state_q)
            ST_ACTIVE: begin
                len_m1    = last_idx(cfg_i.active);
                state_nxt = ST_FP;
            end
            ST_FP: begin
                len_m1    = last_idx(cfg_i.fp);
                state_nxt = ST_SYNC;
            end
            ST_SYNC: begin
                len_m1    = last_idx(cfg_i.sync);
                state_nxt = ST_BP;
            end
            ST_BP: begin
                len_m1    = last_idx(cfg_i.bp);
                state_nxt = ST_ACTIVE;
            end
            default: begin
                len_m1    = '0;
                state_nxt = ST_ACTIVE;
            end
        endcase
    end

    assign phase_end = (cnt_q == len_m1);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (clr_i) begin
            state_d = ST_ACTIVE;
            cnt_d   = '0;
        end else if (adv_i) begin
            if (phase_end) begin
                state_d = state_nxt;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + cnt_t'(1);
            end
        end
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            state_q <= ST_ACTIVE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o = state_q;
    assign count_o = cnt_q;
    assign last_o  = (state_q == ST_BP) && phase_end;

endmodule

// File: rtl/display_timing_gen.sv
// Programmable raster timing generator.
//   ACLK    : pixel clock
//   ARESETN : asynchronous active-low reset
//   bus     : display_timing_gen_if.slave (cfg_* mode registers in, video timing out)
// Two display_timing_axis instances (H advances every running cycle, V on H line end)
// feed a layer of output registers, so every output lags the axis state by one cycle;
// only the sync polarity XOR is combinational.
// Build option DISPLAY_TIMING_SHADOW_EN: when defined, all cfg_* lengths and polarities
// are captured on the IDLE->run transition and at every frame end, so mid-frame writes
// apply from the next frame; otherwise cfg_* is used live.
module display_timing_gen
    import display_timing_pkg::*;
(
    input logic           ACLK,
    input logic           ARESETN,
    display_timing_gen_if.slave bus
);

    ctrl_state_t ctrl_q, ctrl_d;
    logic        run;
    logic        frame_end;

    axis_cfg_t   h_cfg, v_cfg;
    logic        hs_pol, vs_pol;

    axis_state_t h_state, v_state;
    cnt_t        h_count, v_count;
    logic        h_last, v_last;

    // ---------------------------------------------------------------------------------
    // Mode source: shadow copies or live registers
    // ---------------------------------------------------------------------------------
`ifdef DISPLAY_TIMING_SHADOW_EN
    axis_cfg_t h_cfg_q, v_cfg_q;
    logic      hs_pol_q, vs_pol_q;
    logic      shadow_load;

    assign shadow_load = ((ctrl_q == ST_IDLE) && bus.cfg_enable) || frame_end;

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            h_cfg_q  <= '0;
            v_cfg_q  <= '0;
            hs_pol_q <= 1'b0;
            vs_pol_q <= 1'b0;
        end else if (shadow_load) begin
            h_cfg_q  <= '{active: bus.cfg_h_active, fp: bus.cfg_h_fp,
                          sync: bus.cfg_h_sync, bp: bus.cfg_h_bp};
            v_cfg_q  <= '{active: bus.cfg_v_active, fp: bus.cfg_v_fp,
                          sync: bus.cfg_v_sync, bp: bus.cfg_v_bp};
            hs_pol_q <= bus.cfg_hs_pol;
            vs_pol_q <= bus.cfg_vs_pol;
        end
    end

    assign h_cfg  = h_cfg_q;
    assign v_cfg  = v_cfg_q;
    assign hs_pol = hs_pol_q;
    assign vs_pol = vs_pol_q;
`else
    assign h_cfg  = '{active: bus.cfg_h_active, fp: bus.cfg_h_fp,
                      sync: bus.cfg_h_sync, bp: bus.cfg_h_bp};
    assign v_cfg  = '{active: bus.cfg_v_active, fp: bus.cfg_v_fp,
                      sync: bus.cfg_v_sync, bp: bus.cfg_v_bp};
    assign hs_pol = bus.cfg_hs_pol;
    assign vs_pol = bus.cfg_vs_pol;
`endif

    // ---------------------------------------------------------------------------------
    // Axes
    // ---------------------------------------------------------------------------------
    display_timing_axis u_h_axis (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .clr_i   (!run),
        .adv_i   (run),
        .cfg_i   (h_cfg),
        .state_o (h_state),
        .count_o (h_count),
        .last_o  (h_last)
    );

    // h_last can only be true while running, so it doubles as the V advance.
    display_timing_axis u_v_axis (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .clr_i   (!run),
        .adv_i   (h_last),
        .cfg_i   (v_cfg),
        .state_o (v_state),
        .count_o (v_count),
        .last_o  (v_last)
    );

    // ---------------------------------------------------------------------------------
    // IDLE / run control
    // ---------------------------------------------------------------------------------
    assign run       = (ctrl_q == ST_RUN);
    assign frame_end = run && h_last && v_last;

    always_comb begin
        ctrl_d = ctrl_q;
        unique case (ctrl_q)
            ST_IDLE: if (bus.cfg_enable) ctrl_d = ST_RUN;
            // Disable is honoured only at frame end so frames are never truncated.
            ST_RUN:  if (frame_end && !bus.cfg_enable) ctrl_d = ST_IDLE;
            default: ctrl_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ctrl_q <= ST_IDLE;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    // ---------------------------------------------------------------------------------
    // Output registers
    // ---------------------------------------------------------------------------------
    logic de_q, de_d;
    logic hs_act_q, hs_act_d;
    logic vs_act_q, vs_act_d;
    cnt_t pix_x_q, pix_x_d;
    cnt_t pix_y_q, pix_y_d;
    logic frame_start_q, frame_start_d;
    logic line_start_q, line_start_d;
    logic running_q, running_d;
    logic h_act, v_act, h_first;

    always_comb begin
        h_act   = (h_state == ST_ACTIVE);
        v_act   = (v_state == ST_ACTIVE);
        h_first = h_act && (h_count == '0);

        de_d          = run && h_act && v_act;
        hs_act_d      = run && (h_state == ST_SYNC);
        vs_act_d      = run && (v_state == ST_SYNC);
        pix_x_d       = h_act ? h_count : '0;
        pix_y_d       = v_act ? v_count : '0;
        frame_start_d = run && h_first && v_act && (v_count == '0);
        line_start_d  = run && h_first && v_act;
        running_d     = run;
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            de_q          <= 1'b0;
            hs_act_q      <= 1'b0;
            vs_act_q      <= 1'b0;
            pix_x_q       <= '0;
            pix_y_q       <= '0;
            frame_start_q <= 1'b0;
            line_start_q  <= 1'b0;
            running_q     <= 1'b0;
        end else begin
            de_q          <= de_d;
            hs_act_q      <= hs_act_d;
            vs_act_q      <= vs_act_d;
            pix_x_q       <= pix_x_d;
            pix_y_q       <= pix_y_d;
            frame_start_q <= frame_start_d;
            line_start_q  <= line_start_d;
            running_q     <= running_d;
        end
    end

    assign bus.de          = de_q;
    assign bus.hsync       = hs_act_q ^ hs_pol;
    assign bus.vsync       = vs_act_q ^ vs_pol;
    assign bus.pix_x       = pix_x_q;
    assign bus.pix_y       = pix_y_q;
    assign bus.frame_start = frame_start_q;
    assign bus.line_start  = line_start_q;
    assign bus.running     = running_q;

endmodule

// File: tb/tb_display_timing_gen.sv
// Directed bench for display_timing_gen using the base mode H=4/1/2/1, V=3/1/1/1.
// Expected values come from the raster layout: output cycle c of a frame sits at
// line c/L, x c%L with L = h_active+4; de for x<h_active on lines 0-2, hsync on
// x = h_active+1..h_active+2, vsync on line 4.
module tb_display_timing_gen;

    logic aclk;
    logic aresetn;
    int   n_checks;
    int   n_fail;

    display_timing_gen_if bus ();

    display_timing_gen dut (
        .ACLK    (aclk),
        .ARESETN (aresetn),
        .bus     (bus)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout required end of test");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic set_base_mode();
        bus.cfg_h_active = 12'd4;
        bus.cfg_h_fp     = 12'd1;
        bus.cfg_h_sync   = 12'd2;
        bus.cfg_h_bp     = 12'd1;
        bus.cfg_v_active = 12'd3;
        bus.cfg_v_fp     = 12'd1;
        bus.cfg_v_sync   = 12'd1;
        bus.cfg_v_bp     = 12'd1;
        bus.cfg_hs_pol   = 1'b0;
        bus.cfg_vs_pol   = 1'b0;
    endtask

    // Raise enable so edge N samples it; returns just after edge N.
    task automatic start();
        @(negedge aclk);
        bus.cfg_enable = 1'b1;
        @(negedge aclk);
        check("running_before_first_pixel", 32'(bus.running), 32'd0);
        check("de_before_first_pixel", 32'(bus.de), 32'd0);
    endtask

    // Checks one frame whose first output cycle is the next negedge.
    task automatic check_frame(input int h_act, input int drop_c, input int write_c,
                               input logic hpol);
        int   line_len;
        int   x;
        int   ln;
        logic e_de;
        logic e_hs;
        line_len = h_act + 4;
        for (int c = 0; c < line_len * 6; c++) begin
            @(negedge aclk);
            x    = c % line_len;
            ln   = c / line_len;
            e_de = (ln < 3) && (x < h_act);
            e_hs = ((x == h_act + 1) || (x == h_act + 2)) ^ hpol;
            check("de", 32'(bus.de), 32'(e_de));
            check("hsync", 32'(bus.hsync), 32'(e_hs));
            check("vsync", 32'(bus.vsync), 32'(ln == 4));
            check("frame_start", 32'(bus.frame_start), 32'(c == 0));
            check("line_start", 32'(bus.line_start), 32'((x == 0) && (ln < 3)));
            check("running", 32'(bus.running), 32'd1);
            if (e_de) begin
                check("pix_x", 32'(bus.pix_x), 32'(x));
                check("pix_y", 32'(bus.pix_y), 32'(ln));
            end
            if (c == drop_c) bus.cfg_enable = 1'b0;
            if (c == write_c) bus.cfg_h_active = 12'd6;
        end
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge aclk);
            check("idle_running", 32'(bus.running), 32'd0);
            check("idle_de", 32'(bus.de), 32'd0);
            check("idle_frame_start", 32'(bus.frame_start), 32'd0);
            check("idle_line_start", 32'(bus.line_start), 32'd0);
        end
    endtask

    initial begin
        n_checks       = 0;
        n_fail         = 0;
        aresetn        = 1'b0;
        bus.cfg_enable = 1'b0;
        set_base_mode();

        // Reset values
        #12;
        check("rst_de", 32'(bus.de), 32'd0);
        check("rst_running", 32'(bus.running), 32'd0);
        check("rst_hsync", 32'(bus.hsync), 32'd0);
        check("rst_vsync", 32'(bus.vsync), 32'd0);
        check("rst_pix_x", 32'(bus.pix_x), 32'd0);
        check("rst_pix_y", 32'(bus.pix_y), 32'd0);
        check("rst_frame_start", 32'(bus.frame_start), 32'd0);
        check("rst_line_start", 32'(bus.line_start), 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        idle_check(3);

        // Three back-to-back frames, then a fourth with enable dropped in line 1
        start();
        check_frame(4, -1, -1, 1'b0);
        check_frame(4, -1, -1, 1'b0);
        check_frame(4, -1, -1, 1'b0);
        check_frame(4, 10, -1, 1'b0);
        idle_check(12);

        // Re-enable restarts at (0,0)
        start();
        check_frame(4, 5, -1, 1'b0);
        idle_check(4);

        // Zero-length fields behave as one: same 48-cycle frame
        bus.cfg_h_fp = 12'd0;
        bus.cfg_v_bp = 12'd0;
        start();
        check_frame(4, -1, -1, 1'b0);
        check_frame(4, 3, -1, 1'b0);
        idle_check(4);
        set_base_mode();

        // Active-low hsync
        bus.cfg_hs_pol = 1'b1;
        @(negedge aclk);
`ifdef DISPLAY_TIMING_SHADOW_EN
        check("idle_hsync_pol1", 32'(bus.hsync), 32'd0);
`else
        check("idle_hsync_pol1", 32'(bus.hsync), 32'd1);
`endif
        start();
        check_frame(4, 0, -1, 1'b1);
        idle_check(4);

        // Asynchronous reset at line 2, cycle 3
        start();
        repeat (20) @(negedge aclk);
        check("pre_rst_de", 32'(bus.de), 32'd1);
        check("pre_rst_pix_x", 32'(bus.pix_x), 32'd3);
        check("pre_rst_pix_y", 32'(bus.pix_y), 32'd2);
        #2;
        aresetn = 1'b0;
        bus.cfg_enable = 1'b0;
        #1;
        check("async_rst_de", 32'(bus.de), 32'd0);
        check("async_rst_running", 32'(bus.running), 32'd0);
        check("async_rst_pix_x", 32'(bus.pix_x), 32'd0);
        check("async_rst_pix_y", 32'(bus.pix_y), 32'd0);
        check("async_rst_vsync", 32'(bus.vsync), 32'd0);
`ifdef DISPLAY_TIMING_SHADOW_EN
        check("async_rst_hsync", 32'(bus.hsync), 32'd0);
`else
        check("async_rst_hsync", 32'(bus.hsync), 32'd1);
`endif
        repeat (2) @(negedge aclk);
        bus.cfg_hs_pol = 1'b0;
        aresetn = 1'b1;
        idle_check(3);

`ifdef DISPLAY_TIMING_SHADOW_EN
        // Mid-frame h_active write applies to the next frame only (period 60)
        start();
        check_frame(4, -1, 20, 1'b0);
        check_frame(6, 5, -1, 1'b0);
        idle_check(4);
        set_base_mode();
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
